// File: rtl/adsr_key_ctrl.sv
// adsr_key_ctrl: turns note-on/off/panic events into keystate read-modify-writes on ADSR RAM port A
//   clk, reset (async, active-low)
//   ev_valid/ev_ready/ev_type/ev_note/ev_velocity : event handshake
//   adsr_addr/adsr_din/adsr_write_en/adsr_dout    : RAM port A (read data 1 clk after address)
//   assign_valid/assign_voice/assign_note/assign_velocity : note-on bound to a voice
//   drop                                          : note-on discarded, no voice available
//   note_rd_addr/note_rd_data                     : registered per-voice note table read
module adsr_key_ctrl #(
    parameter int NUM_VOICES = 16,
    parameter int DATA_WIDTH = 38
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ev_valid,
    output logic         ev_ready,
    input  logic [1:0]   ev_type,
    input  logic [6:0]   ev_note,
    input  logic [6:0]   ev_velocity,
    output logic [7:0]   adsr_addr,
    output logic [127:0] adsr_din,
    output logic         adsr_write_en,
    input  logic [127:0] adsr_dout,
    output logic         assign_valid,
    output logic [7:0]   assign_voice,
    output logic [6:0]   assign_note,
    output logic [6:0]   assign_velocity,
    output logic         drop,
    input  logic [7:0]   note_rd_addr,
    output logic [6:0]   note_rd_data
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [7:0] LAST = 8'(NUM_VOICES - 1);

    typedef enum logic [2:0] {IDLE, SCAN_ADDR, SCAN_EVAL, RMW_ADDR, RMW_WAIT, RMW_WRITE, REPORT} state_t;

    state_t state, state_nx;
    logic [1:0] ev_type_q;
    logic [6:0] note_q, vel_q;
    logic [7:0] v, tgt;
    logic f_same, f_free, f_rel;
    logic [7:0] i_same, i_free, i_rel;
    logic [NUM_VOICES-1:0][6:0] note_tbl;
    logic is_on, is_panic, last, same_hit, free_hit, rel_hit, n_same, n_free, n_rel, found;
    logic [7:0] n_same_i, n_free_i, n_rel_i, pick;
    logic [127-DATA_WIDTH:0] unused_dout;

    assign unused_dout = adsr_dout[127:DATA_WIDTH];
    assign is_on = ev_type_q == 2'd1;
    assign is_panic = ev_type_q == 2'd2;
    assign last = v == LAST;
    // The "same note" class doubles as the note-off target: a held key with this note.
    assign same_hit = note_tbl[v[VW-1:0]] == note_q &&
                      (is_on ? (adsr_dout[4:1] != 4'd0 || adsr_dout[0]) : adsr_dout[0]);
    assign free_hit = adsr_dout[4:1] == 4'd0 && !adsr_dout[0];
    assign rel_hit = adsr_dout[4:1] == 4'd3;
    assign n_same = f_same | same_hit;
    assign n_free = f_free | free_hit;
    assign n_rel = f_rel | rel_hit;
    assign n_same_i = f_same ? i_same : v;
    assign n_free_i = f_free ? i_free : v;
    assign n_rel_i = f_rel ? i_rel : v;
    assign pick = n_same ? n_same_i : n_free ? n_free_i : n_rel_i;
    assign found = n_same | (is_on & (n_free | n_rel));

    always_comb begin
        state_nx = state;
        drop = 1'b0;
        case (state)
            IDLE:      state_nx = (ev_valid && ev_type != 2'd3) ? SCAN_ADDR : IDLE;
            SCAN_ADDR: state_nx = SCAN_EVAL;
            SCAN_EVAL: begin
                if (is_panic) state_nx = adsr_dout[0] ? RMW_ADDR : last ? IDLE : SCAN_ADDR;
                else if (!last) state_nx = SCAN_ADDR;
                else begin
                    state_nx = found ? RMW_ADDR : IDLE;
                    drop = is_on && !found;
                end
            end
            RMW_ADDR:  state_nx = RMW_WAIT;
            RMW_WAIT:  state_nx = RMW_WRITE;
            RMW_WRITE: state_nx = is_on ? REPORT : (is_panic && !last) ? SCAN_ADDR : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ev_type_q <= 2'd0;
            note_q <= 7'd0;
            vel_q <= 7'd0;
            v <= 8'd0;
            tgt <= 8'd0;
            f_same <= 1'b0;
            f_free <= 1'b0;
            f_rel <= 1'b0;
            i_same <= 8'd0;
            i_free <= 8'd0;
            i_rel <= 8'd0;
            note_tbl <= '0;
            note_rd_data <= 7'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && ev_valid) begin
                ev_type_q <= ev_type;
                note_q <= ev_note;
                vel_q <= ev_velocity;
                v <= 8'd0;
                f_same <= 1'b0;
                f_free <= 1'b0;
                f_rel <= 1'b0;
            end
            if (state == SCAN_EVAL) begin
                f_same <= n_same;
                f_free <= n_free;
                f_rel <= n_rel;
                i_same <= n_same_i;
                i_free <= n_free_i;
                i_rel <= n_rel_i;
                tgt <= is_panic ? v : pick;
            end
            if (state != IDLE && state_nx == SCAN_ADDR) v <= v + 8'd1;
            if (state == REPORT) note_tbl[tgt[VW-1:0]] <= note_q;
            note_rd_data <= (32'(note_rd_addr) < NUM_VOICES) ? note_tbl[note_rd_addr[VW-1:0]] : 7'd0;
        end
    end

    assign ev_ready = state == IDLE;
    // Address stays on the target through the write so the RAM output in RMW_WRITE is the freshest word.
    assign adsr_addr = (state == SCAN_ADDR || state == SCAN_EVAL) ? v :
                       (state inside {RMW_ADDR, RMW_WAIT, RMW_WRITE}) ? tgt : 8'd0;
    assign adsr_write_en = state == RMW_WRITE;
    assign adsr_din = adsr_write_en ? 128'({adsr_dout[DATA_WIDTH-1:1], is_on}) : 128'd0;
    assign assign_valid = state == REPORT;
    assign assign_voice = assign_valid ? tgt : 8'd0;
    assign assign_note = assign_valid ? note_q : 7'd0;
    assign assign_velocity = assign_valid ? vel_q : 7'd0;
endmodule

// File: tb/tb_adsr_key_ctrl.sv
// tb_adsr_key_ctrl: directed + randomized self-checking bench for adsr_key_ctrl with a RAM model
module tb_adsr_key_ctrl;
  localparam int N = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ev_valid = 1'b0;
  logic [1:0] ev_type = 2'd0;
  logic [6:0] ev_note = 7'd0, ev_velocity = 7'd0;
  logic [7:0] note_rd_addr = 8'd0;
  logic ev_ready, adsr_write_en, assign_valid, drop;
  logic [7:0] adsr_addr, assign_voice;
  logic [127:0] adsr_din, adsr_dout;
  logic [6:0] assign_note, assign_velocity, note_rd_data;
  int checks = 0;
  int errors = 0;
  logic [37:0] mem [256];
  logic bd_en = 1'b0;
  logic [7:0] bd_addr = 8'd0;
  logic [37:0] bd_data = 38'd0;
  logic [37:0] img [N];
  logic [6:0] tbl [N];
  logic [7:0] wq_addr[$];
  logic [127:0] wq_data[$];
  int av_cnt = 0, drop_cnt = 0;
  logic [7:0] av_voice;
  logic [6:0] av_note, av_vel;

  always #5 clk = ~clk;

  adsr_key_ctrl #(.NUM_VOICES(N), .DATA_WIDTH(38)) dut (
    .clk(clk), .reset(reset),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_note(ev_note), .ev_velocity(ev_velocity),
    .adsr_addr(adsr_addr), .adsr_din(adsr_din), .adsr_write_en(adsr_write_en),
    .adsr_dout(adsr_dout),
    .assign_valid(assign_valid), .assign_voice(assign_voice),
    .assign_note(assign_note), .assign_velocity(assign_velocity),
    .drop(drop), .note_rd_addr(note_rd_addr), .note_rd_data(note_rd_data)
  );

  always @(posedge clk) begin
    if (adsr_write_en) mem[adsr_addr] <= adsr_din[37:0];
    else if (bd_en) mem[bd_addr] <= bd_data;
    adsr_dout <= {90'd0, mem[adsr_addr]};
  end

  always @(negedge clk) begin
    if (adsr_write_en) begin
      wq_addr.push_back(adsr_addr);
      wq_data.push_back(adsr_din);
    end
    if (assign_valid) begin
      av_cnt++;
      av_voice = assign_voice;
      av_note = assign_note;
      av_vel = assign_velocity;
    end
    if (drop) drop_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] word(input logic [32:0] env, input logic [3:0] st, input logic k);
    return {env, st, k};
  endfunction

  function automatic logic [32:0] renv();
    return {1'($urandom_range(0, 1)), 32'($urandom)};
  endfunction

  task automatic load_img();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bd_en = 1'b1;
      bd_addr = 8'(i);
      bd_data = img[i];
    end
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic chk_rd(input int a);
    @(negedge clk);
    note_rd_addr = 8'(a);
    @(negedge clk);
    chk("note_rd", note_rd_data, (a < N) ? tbl[a] : 7'd0);
  endtask

  task automatic run_event(input logic [1:0] t, input logic [6:0] n, input logic [6:0] vel);
    logic [7:0] ea[$];
    logic [127:0] ed[$];
    int tv, busy, exp_busy, w0, a0, d0;
    bit exp_as, exp_dr;
    tv = -1;
    exp_as = 0;
    exp_dr = 0;
    exp_busy = 0;
    if (t == 2'd1) begin
      for (int i = 0; i < N; i++) if (tv < 0 && tbl[i] == n && (mem[i][4:1] != 4'd0 || mem[i][0])) tv = i;
      for (int i = 0; i < N; i++) if (tv < 0 && mem[i][4:0] == 5'd0) tv = i;
      for (int i = 0; i < N; i++) if (tv < 0 && mem[i][4:1] == 4'd3) tv = i;
      if (tv >= 0) begin
        ea.push_back(8'(tv));
        ed.push_back({90'd0, mem[tv][37:1], 1'b1});
        exp_as = 1;
        exp_busy = 2 * N + 4;
      end else begin
        exp_dr = 1;
        exp_busy = 2 * N;
      end
    end else if (t == 2'd0) begin
      for (int i = 0; i < N; i++) if (tv < 0 && tbl[i] == n && mem[i][0]) tv = i;
      exp_busy = 2 * N;
      if (tv >= 0) begin
        ea.push_back(8'(tv));
        ed.push_back({90'd0, mem[tv][37:1], 1'b0});
        exp_busy += 3;
      end
    end else if (t == 2'd2) begin
      exp_busy = 2 * N;
      for (int i = 0; i < N; i++) if (mem[i][0]) begin
        ea.push_back(8'(i));
        ed.push_back({90'd0, mem[i][37:1], 1'b0});
        exp_busy += 3;
      end
    end
    w0 = wq_addr.size();
    a0 = av_cnt;
    d0 = drop_cnt;
    @(negedge clk);
    chk("ready_before", ev_ready, 1'b1);
    ev_valid = 1'b1;
    ev_type = t;
    ev_note = n;
    ev_velocity = vel;
    @(negedge clk);
    ev_valid = 1'b0;
    busy = 0;
    while (!ev_ready && busy < 2000) begin
      busy++;
      @(negedge clk);
    end
    chk("busy_cycles", busy, exp_busy);
    chk("write_count", wq_addr.size() - w0, ea.size());
    for (int i = 0; i < ea.size() && w0 + i < wq_addr.size(); i++) begin
      chk("write_addr", wq_addr[w0 + i], ea[i]);
      chk("write_data", wq_data[w0 + i], ed[i]);
    end
    chk("assign_count", av_cnt - a0, exp_as ? 1 : 0);
    if (exp_as) begin
      chk("assign_voice", av_voice, 8'(tv));
      chk("assign_note", av_note, n);
      chk("assign_vel", av_vel, vel);
      tbl[tv] = n;
    end
    chk("drop_count", drop_cnt - d0, exp_dr ? 1 : 0);
  endtask

  initial begin
    int w0, a0;
    for (int i = 0; i < N; i++) tbl[i] = 7'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ev_ready, 1'b1);
    chk("rst_we", adsr_write_en, 1'b0);
    chk("rst_addr", adsr_addr, 8'd0);
    chk("rst_din", adsr_din, 128'd0);
    chk("rst_assign", {assign_valid, assign_voice, assign_note, assign_velocity}, 23'd0);
    chk("rst_drop", drop, 1'b0);
    chk("rst_note_rd", note_rd_data, 7'd0);
    reset = 1'b1;
    for (int i = 0; i < N; i++) img[i] = 38'd0;
    load_img();
    run_event(2'd1, 7'd60, 7'd100);
    chk("first_din", wq_data[wq_data.size() - 1], 128'd1);
    chk("first_voice", av_voice, 8'd0);
    chk_rd(0);
    run_event(2'd1, 7'd62, 7'd90);
    run_event(2'd1, 7'd64, 7'd80);
    img[0] = word(33'd0, 4'd2, 1'b1);
    img[1] = word(33'h0_8000_0000, 4'd2, 1'b1);
    img[2] = word(33'd0, 4'd2, 1'b1);
    load_img();
    run_event(2'd0, 7'd62, 7'd0);
    chk("off_addr", wq_addr[wq_addr.size() - 1], 8'd1);
    chk("off_din", wq_data[wq_data.size() - 1], 128'h10_0000_0004);
    for (int i = 0; i < N; i++) img[i] = word(renv(), 4'd2, 1'b1);
    img[5] = word(renv(), 4'd3, 1'b0);
    load_img();
    run_event(2'd1, 7'd70, 7'd55);
    chk("rel_voice", av_voice, 8'd5);
    img[5] = word(renv(), 4'd2, 1'b1);
    load_img();
    run_event(2'd1, 7'd71, 7'd33);
    for (int i = 0; i < N; i++) img[i] = word(renv(), 4'd0, 1'b0);
    img[3] = word(renv(), 4'd1, 1'b1);
    img[9] = word(renv(), 4'd4, 1'b1);
    load_img();
    run_event(2'd2, 7'd0, 7'd0);
    chk("panic_a0", wq_addr[wq_addr.size() - 2], 8'd3);
    chk("panic_a1", wq_addr[wq_addr.size() - 1], 8'd9);
    run_event(2'd0, 7'd100, 7'd0);
    run_event(2'd3, 7'd60, 7'd10);
    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        int sel;
        logic [3:0] st;
        sel = $urandom_range(0, mode == 0 ? 4 : mode == 1 ? 3 : 1);
        st = sel == 0 ? 4'd2 : sel == 1 ? 4'($urandom_range(4, 15)) :
             sel == 2 ? 4'd3 : sel == 3 ? 4'd1 : 4'd0;
        img[i] = word(renv(), st, 1'($urandom_range(0, 1)));
      end
      load_img();
      run_event(2'($urandom_range(0, 3)), 7'(60 + $urandom_range(0, 3)), 7'($urandom_range(0, 127)));
      chk_rd($urandom_range(0, N + 3));
    end
    for (int i = 0; i < N; i++) img[i] = 38'd0;
    load_img();
    w0 = wq_addr.size();
    a0 = av_cnt;
    @(negedge clk);
    ev_valid = 1'b1;
    ev_type = 2'd1;
    ev_note = 7'd50;
    ev_velocity = 7'd20;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (2 * N + 1) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_we", adsr_write_en, 1'b0);
    chk("abort_ready", ev_ready, 1'b1);
    chk("abort_addr", adsr_addr, 8'd0);
    chk("abort_din", adsr_din, 128'd0);
    repeat (3) @(negedge clk);
    chk("abort_writes", wq_addr.size() - w0, 0);
    chk("abort_assign", av_cnt - a0, 0);
    chk("abort_note_rd", note_rd_data, 7'd0);
    reset = 1'b1;
    for (int i = 0; i < N; i++) tbl[i] = 7'd0;
    chk_rd(0);
    run_event(2'd1, 7'd50, 7'd20);
    chk("post_reset_voice", av_voice, 8'd0);
    chk_rd(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adsr_key_ctrl.md
Name: adsr_key_ctrl

Overview:
- Voice-controller-side driver of the ADSR parameter RAM port A (the port opposite the envelope engine).
- Converts note-on/note-off/panic events into keystate writes (word bit 0) for a chosen voice and keeps a per-voice note table for the oscillator bank.
- Finds voices by scanning the ADSR RAM: envelope word [37:5], state [4:1], keystate [0]. The envelope engine owns bits [37:1]. This block changes bit 0 only, by read-modify-write.

Parameters:
- NUM_VOICES, 16, voices scanned, indices 0..NUM_VOICES-1 (max 256)
- DATA_WIDTH, 38, meaningful ADSR word width; bits above it are driven 0

Ports:
- clk  in  1  clock
- reset  in  1  async active-low reset
- ev_valid  in  1  event request
- ev_ready  out  1  block idle; an event is accepted on ev_valid & ev_ready
- ev_type  in  2  0 note-off, 1 note-on, 2 panic (all keys off), 3 ignored (consumed, no action)
- ev_note  in  7  MIDI note number
- ev_velocity  in  7  MIDI velocity (note-on only)
- adsr_addr  out  8  RAM port A address
- adsr_din  out  128  RAM port A write data
- adsr_write_en  out  1  RAM port A write strobe
- adsr_dout  in  128  RAM port A read data, valid 1 clk after adsr_addr
- assign_valid  out  1  1-cycle pulse: note-on bound to a voice
- assign_voice  out  8  voice index for assign_valid
- assign_note  out  7  note for assign_valid
- assign_velocity  out  7  velocity for assign_valid
- drop  out  1  1-cycle pulse: note-on discarded, no voice available
- note_rd_addr  in  8  note-table read address
- note_rd_data  out  7  registered note_tbl[note_rd_addr], 1-clk latency; 0 if address out of range

Behaviour:
- Reset state: FSM IDLE; ev_ready=1; adsr_addr=0, adsr_din=0, adsr_write_en=0; assign_*=0; drop=0; note_rd_data=0; every note_tbl entry = 0.
- States: IDLE, SCAN_ADDR, SCAN_EVAL, RMW_ADDR, RMW_WAIT, RMW_WRITE, REPORT.
- IDLE: ev_ready=1. On handshake, latch type, note and velocity. Set ev_ready=0 and scan index v=0, then go to SCAN_ADDR. Type 3 events are consumed in IDLE with no other action.
- SCAN_ADDR: adsr_addr=v. Go to SCAN_EVAL.
- SCAN_EVAL: evaluate word w=adsr_dout[37:0] for voice v. Each voice costs 2 clk; a full scan is 2*NUM_VOICES clk.
  - note-on: record the first match in each class, in this priority order:
    1. same note: note_tbl[v]==note and (w[4:1]!=0 or w[0]==1)
    2. free: w[4:1]==0 and w[0]==0
    3. releasing: w[4:1]==3
  - note-off: target is the first v with note_tbl[v]==note and w[0]==1.
  - panic: every v with w[0]==1 is queued for RMW immediately. Go to RMW_ADDR, then resume the scan at v+1.
  - At v==NUM_VOICES-1, choose the target:
    - note-on: the highest-priority class found. If no class matched, pulse drop and return to IDLE.
    - note-off: if no target, return to IDLE silently. Otherwise go to RMW_ADDR.
- RMW_ADDR / RMW_WAIT / RMW_WRITE:
  - Re-read the target word; this minimises the race with the envelope engine.
  - In RMW_WRITE, for 1 clk: adsr_write_en=1, adsr_din={zeros, fresh[37:1], k}. k=1 for note-on; k=0 for note-off and panic.
  - adsr_write_en is 0 in every other state.
- REPORT (note-on only):
  - note_tbl[target] <= note.
  - 1-clk assign_valid with voice, note and velocity.
  - Then IDLE.
- Note-off and panic skip REPORT and return to IDLE. ev_ready rises the cycle after the final write (or after drop).
- Retrigger: a note-on for a note already held rewrites keystate=1 to the same voice (a no-op in the word) and still pulses assign_valid.
- Reset mid-operation: abort immediately. No write may complete after reset asserts. The note table is cleared.
- note_rd port operates in every state and is independent of the FSM.
- Upper adsr_din bits [127:DATA_WIDTH] are always 0.

Test Plan:
- After reset, RAM all zero; note-on note 60, velocity 100 -> exactly one write to addr 0 with din=1; assign_valid with voice 0, note 60, velocity 100; note_rd_addr=0 gives 60; ev_ready low for 2*16+4 clk.
- Voices 0-2 keystate=1 with notes 60, 62, 64; note-off 62 -> single write to addr 1 with bit 0 cleared and bits [37:1] preserved (preload envelope 33'h0_8000_0000, state 2 -> din=38'h10_0000_0004); no assign_valid.
- All 16 voices state 2, keystate 1; voice 5 state 3 keystate 0; note-on 70 -> voice 5 written with keystate=1, assign_voice=5. With no state-3 voice -> drop pulses, no write.
- Voices 3 and 9 keystate=1; panic -> exactly two writes (addr 3, then addr 9), each clearing bit 0; others untouched.
- Note-off for a note not held -> no write, no pulses, ev_ready returns after the scan.
- Assert reset during RMW_WAIT of a note-on -> no adsr_write_en pulse; outputs at reset values; a subsequent note-on scans from voice 0.
